// File: rtl/win_detector_fsm.sv
// rtl/win_detector_fsm.sv - slot screen win classifier with buzzer timer and saturating score
// Define WIN_MIRROR_EN to enable the mirror pattern (win_code 3).
module win_detector_fsm #(
   parameter int NUM_CELLS   = 8,
   parameter int CELL_BITS   = 4,
   parameter int BUZZ_CYCLES = 50000000,
   parameter int SCORE_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CELLS*CELL_BITS-1:0] screen,
   input  logic                           stop,
   input  logic                           clear,
   output logic                           buzz,
   output logic                           win,
   output logic [1:0]                     win_code,
   output logic [SCORE_WIDTH-1:0]         score
);
   localparam int SCREEN_W = NUM_CELLS * CELL_BITS;
   localparam int CNT_W    = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUZZ_CYCLES - 1);
   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = {SCORE_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      BUZZ = 2'd2
   } state_t;

   state_t                 state, state_nx;
   logic [SCREEN_W-1:0]    sample, sample_nx;
   logic [CNT_W-1:0]       cnt, cnt_nx;
   logic                   buzz_nx, win_nx;
   logic [1:0]             win_code_nx, code;
   logic [SCORE_WIDTH-1:0] score_nx;
   logic                   all_equal, alternating, mirror;

   // Pattern classification of the captured screen, highest priority first.
   always_comb begin
      all_equal   = 1'b1;
      alternating = (sample[0 +: CELL_BITS] != sample[CELL_BITS +: CELL_BITS]);
      mirror      = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (sample[i*CELL_BITS +: CELL_BITS] != sample[0 +: CELL_BITS])
            all_equal = 1'b0;
         if (sample[i*CELL_BITS +: CELL_BITS] != sample[(i%2)*CELL_BITS +: CELL_BITS])
            alternating = 1'b0;
      end
`ifdef WIN_MIRROR_EN
      mirror = 1'b1;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (sample[i*CELL_BITS +: CELL_BITS] != sample[(NUM_CELLS-1-i)*CELL_BITS +: CELL_BITS])
            mirror = 1'b0;
      end
`endif
      if (all_equal)
         code = 2'd1;
      else if (alternating)
         code = 2'd2;
      else if (mirror)
         code = 2'd3;
      else
         code = 2'd0;
   end

   always_comb begin
      state_nx    = state;
      sample_nx   = sample;
      cnt_nx      = cnt;
      buzz_nx     = buzz;
      win_nx      = 1'b0;
      win_code_nx = win_code;
      score_nx    = score;
      if (clear) begin
         state_nx    = IDLE;
         cnt_nx      = '0;
         buzz_nx     = 1'b0;
         win_code_nx = 2'd0;
         score_nx    = '0;
      end else begin
         case (state)
            IDLE: begin
               if (stop) begin
                  sample_nx = screen;
                  state_nx  = EVAL;
               end
            end
            EVAL: begin
               win_code_nx = code;
               if (code != 2'd0) begin
                  win_nx   = 1'b1;
                  buzz_nx  = 1'b1;
                  cnt_nx   = CNT_LOAD;
                  state_nx = BUZZ;
                  if (score != SCORE_MAX)
                     score_nx = score + 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
            BUZZ: begin
               // Loaded with BUZZ_CYCLES-1 so buzz spans exactly BUZZ_CYCLES cycles.
               if (cnt == '0) begin
                  buzz_nx  = 1'b0;
                  state_nx = IDLE;
               end else begin
                  cnt_nx = cnt - 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sample   <= '0;
         cnt      <= '0;
         buzz     <= 1'b0;
         win      <= 1'b0;
         win_code <= 2'd0;
         score    <= '0;
      end else begin
         state    <= state_nx;
         sample   <= sample_nx;
         cnt      <= cnt_nx;
         buzz     <= buzz_nx;
         win      <= win_nx;
         win_code <= win_code_nx;
         score    <= score_nx;
      end
   end
endmodule
